// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the digit-serial BCD arithmetic blocks.
package bcd_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned BCD_MAX  = 9;
  localparam int unsigned BCD_BASE = 10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSub  = 2'd1,
    StComp = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtractor: d = x - y - bin, corrected by +10 when a borrow is produced.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  logic [DIGIT_W:0] raw;

  // One extra bit so the sign of the raw difference doubles as the borrow out.
  assign raw  = {1'b0, x} - {1'b0, y} - {{DIGIT_W{1'b0}}, bin};
  assign bout = raw[DIGIT_W];
  assign d    = bout ? raw[DIGIT_W-1:0] + DIGIT_W'(BCD_BASE) : raw[DIGIT_W-1:0];

endmodule

// File: rtl/bcd_serial_sub.sv
// Digit-serial |a - b| on packed BCD operands, LSD first; a negative raw result is
// ten's-complemented in a second serial pass to yield the magnitude.
module bcd_serial_sub
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIGITS*DIGIT_W-1:0] a,
  input  logic [DIGITS*DIGIT_W-1:0] b,
  output logic [DIGITS*DIGIT_W-1:0] diff,
  output logic                      neg,
  output logic                      invalid,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned OpW  = DIGITS * DIGIT_W;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            borrow_q, borrow_d;
  logic [OpW-1:0]  a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic            neg_q, neg_d;
  logic            invalid_q, invalid_d;

  logic               in_bad;
  logic               last_digit;
  logic [DIGIT_W-1:0] dig_x, dig_y, dig_d;
  logic               dig_bout;

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (a[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX) ||
          b[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX)) begin
        in_bad = 1'b1;
      end
    end
  end

  // COMP reuses the same digit subtractor with a zero minuend and diff as subtrahend.
  always_comb begin
    dig_x = '0;
    dig_y = diff_q[idx_q*DIGIT_W +: DIGIT_W];
    if (state_q == StSub) begin
      dig_x = a_q[idx_q*DIGIT_W +: DIGIT_W];
      dig_y = b_q[idx_q*DIGIT_W +: DIGIT_W];
    end
  end

  bcd_digit_sub u_digit_sub (
    .x    (dig_x),
    .y    (dig_y),
    .bin  (borrow_q),
    .d    (dig_d),
    .bout (dig_bout)
  );

  assign last_digit = (idx_q == IdxW'(DIGITS - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    borrow_d  = borrow_q;
    a_d       = a_q;
    b_d       = b_q;
    diff_d    = diff_q;
    neg_d     = neg_q;
    invalid_d = invalid_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          idx_d     = '0;
          borrow_d  = 1'b0;
          neg_d     = 1'b0;
          diff_d    = '0;
          invalid_d = in_bad;
          state_d   = in_bad ? StDone : StSub;
        end
      end
      StSub, StComp: begin
        diff_d[idx_q*DIGIT_W +: DIGIT_W] = dig_d;
        borrow_d = dig_bout;
        idx_d    = idx_q + 1'b1;
        if (last_digit) begin
          idx_d = '0;
          if (state_q == StSub && dig_bout) begin
            state_d  = StComp;
            borrow_d = 1'b0;
            neg_d    = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      borrow_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      diff_q    <= '0;
      neg_q     <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      borrow_q  <= borrow_d;
      a_q       <= a_d;
      b_q       <= b_d;
      diff_q    <= diff_d;
      neg_q     <= neg_d;
      invalid_q <= invalid_d;
    end
  end

  assign diff    = diff_q;
  assign neg     = neg_q;
  assign invalid = invalid_q;
  assign busy    = (state_q == StSub) || (state_q == StComp);
  assign done    = (state_q == StDone);

endmodule
